// File: rtl/johnson_seq_checker.sv
// ---------------------------------------------------------------------------
// johnson_seq_checker
//
// Consumer-side checker for a WIDTH-bit twisted-ring (Johnson) counter.
// Each enabled sample of the counter bus is decoded to a phase index. The
// checker then verifies that the phase is the legal successor of the
// previous sample. Once LOCK_CNT consecutive correct transitions have been
// seen, it declares lock. It counts illegal codes and sequence breaks in a
// saturating error counter.
//
// Ports:
//   i_clk      clock, all logic on the rising edge
//   i_srst     synchronous reset, active-high (overrides i_en)
//   i_en       sample enable; i_q is only consumed when high
//   i_q        Johnson counter value from the upstream stage
//   o_phase    decoded phase of the last legal sample
//   o_valid    one-cycle pulse: o_phase was updated
//   o_locked   high while locked onto the sequence
//   o_err      one-cycle pulse: illegal code, or sequence break while locked
//   o_err_cnt  saturating error count (cleared only by i_srst)
//   o_wrap     one-cycle pulse on a locked N-1 -> 0 transition
//
// Every output is registered and appears one cycle after the sampling edge.
// ---------------------------------------------------------------------------
module johnson_seq_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int CNT_W    = 8,
    parameter int PW       = $clog2(2*WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_srst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_q,
    output logic [PW-1:0]    o_phase,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic             o_wrap
);

    localparam int N  = 2 * WIDTH;
    localparam int GW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT) : 1;

    localparam logic [GW-1:0]    GOOD_LAST  = GW'(LOCK_CNT - 1);
    localparam logic [PW-1:0]    LAST_PHASE = PW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKING  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // Canonical Johnson code for phase p. Phases 0..WIDTH fill ones upward
    // from bit0. Phases WIDTH+1..N-1 then clear zeros upward from bit0.
    function automatic logic [WIDTH-1:0] phase_code(input int p);
        logic [WIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (p <= WIDTH) begin
                c[i] = (i < p);
            end else begin
                c[i] = (i >= p - WIDTH);
            end
        end
        return c;
    endfunction

    state_t           state_q, state_d;
    logic [GW-1:0]    good_q, good_d;
    logic [PW-1:0]    prev_q, prev_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             wrap_q, wrap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             dec_legal;
    logic [PW-1:0]    dec_phase;
    logic [PW-1:0]    exp_phase;

    // Decode: exactly one phase code can match a given input, so the loop
    // never has competing hits. No match means the code is illegal.
    always_comb begin
        dec_legal = 1'b0;
        dec_phase = '0;
        for (int p = 0; p < N; p++) begin
            if (i_q == phase_code(p)) begin
                dec_legal = 1'b1;
                dec_phase = PW'(p);
            end
        end
    end

    // Expected successor of the previous legal phase, modulo N. An explicit
    // wrap keeps this correct when N is not a power of two.
    assign exp_phase = (prev_q == LAST_PHASE) ? '0 : prev_q + 1'b1;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state_q <= UNLOCKED;
            good_q  <= '0;
            prev_q  <= '0;
            phase_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            prev_q  <= prev_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        prev_d  = prev_q;
        phase_d = phase_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        wrap_d  = 1'b0;
        cnt_d   = cnt_q;

        if (i_en) begin
            if (!dec_legal) begin
                // An illegal code drops lock from any state. The phase
                // history is kept so that a later legal code is compared
                // against the last good one.
                err_d   = 1'b1;
                state_d = UNLOCKED;
                good_d  = '0;
            end else begin
                valid_d = 1'b1;
                phase_d = dec_phase;
                prev_d  = dec_phase;
                unique case (state_q)
                    UNLOCKED: begin
                        state_d = LOCKING;
                        good_d  = '0;
                    end
                    LOCKING: begin
                        if (dec_phase == exp_phase) begin
                            if (good_q == GOOD_LAST) begin
                                state_d = LOCKED;
                            end else begin
                                good_d = good_q + 1'b1;
                            end
                        end else begin
                            good_d = '0;
                        end
                    end
                    LOCKED: begin
                        if (dec_phase == exp_phase) begin
                            wrap_d = (prev_q == LAST_PHASE) && (dec_phase == '0);
                        end else begin
                            err_d   = 1'b1;
                            state_d = LOCKING;
                            good_d  = '0;
                        end
                    end
                    default: begin
                        state_d = UNLOCKED;
                        good_d  = '0;
                    end
                endcase
            end

            // Only one error per sample is possible, so a single +1 is
            // enough. The counter sticks at full scale.
            if (err_d && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Output logic
    always_comb begin
        o_phase   = phase_q;
        o_valid   = valid_q;
        o_locked  = (state_q == LOCKED);
        o_err     = err_q;
        o_err_cnt = cnt_q;
        o_wrap    = wrap_q;
    end

endmodule

// File: tb/tb_johnson_seq_checker.sv
// ---------------------------------------------------------------------------
// tb_johnson_seq_checker
//
// Self-checking bench driving two checkers (8-bit and 2-bit error counters)
// with the same stimulus. The stimulus is a directed walk through the
// lock/wrap/error/gap/reset/saturation scenarios, followed by randomized
// traffic. A behavioural model predicts every output each cycle. The model
// decodes codes arithmetically and tracks lock as a run length.
// ---------------------------------------------------------------------------
module tb_johnson_seq_checker;

    localparam int WIDTH    = 4;
    localparam int LOCK_CNT = 3;
    localparam int N        = 2 * WIDTH;
    localparam int PW       = $clog2(N);

    logic             clk = 1'b0;
    logic             srst;
    logic             en;
    logic [WIDTH-1:0] q;

    logic [PW-1:0] ph_a, ph_b;
    logic          vld_a, vld_b, lck_a, lck_b, err_a, err_b, wrap_a, wrap_b;
    logic [7:0]    cnt_a;
    logic [1:0]    cnt_b;

    johnson_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .CNT_W(8)) dut (
        .i_clk(clk), .i_srst(srst), .i_en(en), .i_q(q),
        .o_phase(ph_a), .o_valid(vld_a), .o_locked(lck_a), .o_err(err_a),
        .o_err_cnt(cnt_a), .o_wrap(wrap_a)
    );

    johnson_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .CNT_W(2)) dut_sat (
        .i_clk(clk), .i_srst(srst), .i_en(en), .i_q(q),
        .o_phase(ph_b), .o_valid(vld_b), .o_locked(lck_b), .o_err(err_b),
        .o_err_cnt(cnt_b), .o_wrap(wrap_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;      // 0 unlocked, 1 locking, 2 locked
        int good;
        int prev;
        int phase;
        bit valid;
        bit locked;
        bit err;
        bit wrap;
        int cnt;
    } model_t;

    model_t ma, mb;
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic int popc(input int v);
        int c;
        c = 0;
        for (int i = 0; i < 32; i++) c += (v >> i) & 1;
        return c;
    endfunction

    function automatic int code_of(input int p);
        if (p <= WIDTH) return (1 << p) - 1;
        return ((1 << WIDTH) - 1) & ~((1 << (p - WIDTH)) - 1);
    endfunction

    function automatic model_t model_step(input model_t m, input bit s, input bit e,
                                          input int code, input int cmax);
        model_t r;
        int     z;
        int     ph;
        int     expd;
        bit     legal;
        r       = m;
        r.valid = 0;
        r.err   = 0;
        r.wrap  = 0;
        if (s) begin
            r = '{default: 0};
            return r;
        end
        if (e) begin
            if (((code >> (WIDTH - 1)) & 1) == 0) begin
                legal = ((code & (code + 1)) == 0);
                ph    = popc(code);
            end else begin
                z     = (~code) & ((1 << WIDTH) - 1);
                legal = ((z & (z + 1)) == 0);
                ph    = WIDTH + popc(z);
            end
            if (!legal) begin
                r.err  = 1;
                r.st   = 0;
                r.good = 0;
            end else begin
                expd    = (m.prev + 1) % N;
                r.valid = 1;
                r.phase = ph;
                r.prev  = ph;
                if (m.st == 0) begin
                    r.st   = 1;
                    r.good = 0;
                end else if (m.st == 1) begin
                    if (ph == expd) begin
                        if (m.good == LOCK_CNT - 1) r.st = 2;
                        else r.good = m.good + 1;
                    end else begin
                        r.good = 0;
                    end
                end else begin
                    if (ph == expd) begin
                        r.wrap = (m.prev == N - 1) && (ph == 0);
                    end else begin
                        r.err  = 1;
                        r.st   = 1;
                        r.good = 0;
                    end
                end
            end
            if (r.err && r.cnt < cmax) r.cnt = r.cnt + 1;
        end
        r.locked = (r.st == 2);
        return r;
    endfunction

    task automatic cycle(input bit s, input bit e, input int code);
        int c;
        c    = code & ((1 << WIDTH) - 1);
        srst = s;
        en   = e;
        q    = WIDTH'(c);
        @(posedge clk);
        ma = model_step(ma, s, e, c, 255);
        mb = model_step(mb, s, e, c, 3);
        #1;
        check("a.phase",  int'(ph_a),   ma.phase);
        check("a.valid",  int'(vld_a),  int'(ma.valid));
        check("a.locked", int'(lck_a),  int'(ma.locked));
        check("a.err",    int'(err_a),  int'(ma.err));
        check("a.errcnt", int'(cnt_a),  ma.cnt);
        check("a.wrap",   int'(wrap_a), int'(ma.wrap));
        check("b.phase",  int'(ph_b),   mb.phase);
        check("b.valid",  int'(vld_b),  int'(mb.valid));
        check("b.locked", int'(lck_b),  int'(mb.locked));
        check("b.err",    int'(err_b),  int'(mb.err));
        check("b.errcnt", int'(cnt_b),  mb.cnt);
        check("b.wrap",   int'(wrap_b), int'(mb.wrap));
    endtask

    int sat_exp[6] = '{1, 2, 3, 3, 3, 3};

    initial begin
        int cur;
        int r;
        ma   = '{default: 0};
        mb   = '{default: 0};
        srst = 1'b1;
        en   = 1'b0;
        q    = '0;
        cycle(1, 0, 0);
        cycle(1, 1, 5);
        check("rst.phase", int'(ph_a), 0);
        check("rst.locked", int'(lck_a), 0);
        check("rst.cnt", int'(cnt_a), 0);

        // Lock
        cycle(0, 1, 4'b0000);
        cycle(0, 1, 4'b0001);
        cycle(0, 1, 4'b0011);
        check("t1.locked_early", int'(lck_a), 0);
        cycle(0, 1, 4'b0111);
        check("t1.phase", int'(ph_a), 3);
        check("t1.locked", int'(lck_a), 1);

        // Wrap
        cycle(0, 1, 4'b1111);
        cycle(0, 1, 4'b1110);
        cycle(0, 1, 4'b1100);
        cycle(0, 1, 4'b1000);
        check("t2.phase7", int'(ph_a), 7);
        check("t2.nowrap", int'(wrap_a), 0);
        cycle(0, 1, 4'b0000);
        check("t2.wrap", int'(wrap_a), 1);
        check("t2.phase0", int'(ph_a), 0);

        // Illegal code while locked
        cycle(0, 1, 4'b0101);
        check("t3.err", int'(err_a), 1);
        check("t3.cnt", int'(cnt_a), 1);
        check("t3.valid", int'(vld_a), 0);
        check("t3.hold", int'(ph_a), 0);
        cycle(0, 1, 4'b0001);
        cycle(0, 1, 4'b0011);
        cycle(0, 1, 4'b0111);
        cycle(0, 1, 4'b1111);
        check("t3.relock", int'(lck_a), 1);
        check("t3.phase", int'(ph_a), 4);

        // Sequence break while locked at phase 2
        cycle(0, 1, 4'b1110);
        cycle(0, 1, 4'b1100);
        cycle(0, 1, 4'b1000);
        cycle(0, 1, 4'b0000);
        cycle(0, 1, 4'b0001);
        cycle(0, 1, 4'b0011);
        cycle(0, 1, 4'b1111);
        check("t4.err", int'(err_a), 1);
        check("t4.cnt", int'(cnt_a), 2);
        check("t4.phase", int'(ph_a), 4);
        cycle(0, 1, 4'b1110);
        cycle(0, 1, 4'b1100);
        cycle(0, 1, 4'b1000);
        check("t4.relock", int'(lck_a), 1);

        // Enable gap with garbage, then the legal successor keeps lock
        for (int i = 0; i < 5; i++) cycle(0, 0, int'($urandom_range(0, 15)));
        check("t5.hold", int'(ph_a), 7);
        cycle(0, 1, 4'b0000);
        check("t5.locked", int'(lck_a), 1);
        check("t5.wrap", int'(wrap_a), 1);
        cycle(1, 1, 4'b0001);
        check("t5.rst_locked", int'(lck_a), 0);
        check("t5.rst_cnt", int'(cnt_a), 0);

        // Saturation on the 2-bit counter
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, 4'b0101);
            check("t6.err", int'(err_b), 1);
            check("t6.cnt", int'(cnt_b), sat_exp[i]);
        end
        check("t6.cnt8", int'(cnt_a), 6);

        // Randomized traffic
        cur = 0;
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 70) begin
                cur = (cur + 1) % N;
                cycle(0, 1, code_of(cur));
            end else if (r < 78) begin
                cycle(0, 0, int'($urandom_range(0, 15)));
            end else if (r < 86) begin
                cur = int'($urandom_range(0, N - 1));
                cycle(0, 1, code_of(cur));
            end else if (r < 97) begin
                cycle(0, 1, int'($urandom_range(0, 15)));
            end else begin
                cycle(1, int'($urandom_range(0, 1)) == 1, int'($urandom_range(0, 15)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
